// File: rtl/postfix_evaluator.sv
// Postfix expression evaluator: consumes ASCII postfix tokens over a strobe/ack
// handshake and evaluates them on an operand stack, with a multi-cycle restoring divider.
//
// state   | meaning
// FETCH   | waiting for a token or end of stream
// PUSH    | move the pending accumulator onto the stack
// EXEC    | apply the latched operator to the top two entries
// DIV     | restoring divide, one quotient bit per cycle
// FINAL   | check the final stack depth and publish the result
// DONE    | result valid; tokens acked and discarded
// ERR     | aborted; tokens acked and discarded
module postfix_evaluator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_DAT,
  input  logic             IN_STB,
  input  logic             IN_DONE,
  output logic             IN_ACK,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_STB,
  output logic             ERROR,
  output logic [2:0]       ERR_CODE,
  output logic             BUSY
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_FETCH, S_PUSH, S_EXEC, S_DIV, S_FINAL, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  typedef enum logic [1:0] {AFTER_FETCH, AFTER_EXEC, AFTER_FINAL} after_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  after_t           after_q, after_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_valid_q, acc_valid_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_stb_q, result_stb_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;

  logic [IDX_W-1:0] sp_idx, a_idx, b_idx;
  logic [WIDTH-1:0] op_a, op_b, a_mag, b_mag, quo_next;
  logic [WIDTH:0]   rem_shift, trial;
  logic             q_bit, accept, is_digit, is_op;

  always_comb begin
    sp_idx    = sp_q[IDX_W-1:0];
    b_idx     = sp_idx - IDX_W'(1);
    a_idx     = sp_idx - IDX_W'(2);
    op_a      = stack_q[a_idx];
    op_b      = stack_q[b_idx];
    a_mag     = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
    b_mag     = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
    // Remainder never exceeds the divisor magnitude, so WIDTH bits hold it after restore.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    q_bit     = ~trial[WIDTH];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
    accept    = IN_STB && !ack_q;
    is_digit  = (IN_DAT >= 8'h30) && (IN_DAT <= 8'h39);
    is_op     = (IN_DAT == 8'h2B) || (IN_DAT == 8'h2D) || (IN_DAT == 8'h2A) || (IN_DAT == 8'h2F);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    after_d      = after_q;
    sp_d         = sp_q;
    acc_d        = acc_q;
    acc_valid_d  = acc_valid_q;
    ack_d        = 1'b0;
    result_d     = result_q;
    result_stb_d = result_stb_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    stack_d      = stack_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    neg_d        = neg_q;

    unique case (state_q)
      S_FETCH: begin
        if (accept) begin
          ack_d = 1'b1;
          if (is_digit) begin
            acc_d       = acc_q * WIDTH'(10) + WIDTH'(IN_DAT[3:0]);
            acc_valid_d = 1'b1;
          end else if (IN_DAT == 8'h20) begin
            if (acc_valid_q) begin
              after_d = AFTER_FETCH;
              state_d = S_PUSH;
            end
          end else if (is_op) begin
            unique case (IN_DAT)
              8'h2B:   op_d = OP_ADD;
              8'h2D:   op_d = OP_SUB;
              8'h2A:   op_d = OP_MUL;
              default: op_d = OP_DIV;
            endcase
            after_d = AFTER_EXEC;
            state_d = acc_valid_q ? S_PUSH : S_EXEC;
          end else begin
            error_d    = 1'b1;
            err_code_d = 3'd1;
            state_d    = S_ERR;
          end
        end else if (IN_DONE && !IN_STB) begin
          after_d = AFTER_FINAL;
          state_d = acc_valid_q ? S_PUSH : S_FINAL;
        end
      end
      S_PUSH: begin
        if (sp_q == PTR_W'(DEPTH)) begin
          error_d    = 1'b1;
          err_code_d = 3'd3;
          state_d    = S_ERR;
        end else begin
          stack_d[sp_idx] = acc_q;
          sp_d            = sp_q + PTR_W'(1);
          acc_d           = '0;
          acc_valid_d     = 1'b0;
          unique case (after_q)
            AFTER_EXEC:  state_d = S_EXEC;
            AFTER_FINAL: state_d = S_FINAL;
            default:     state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC: begin
        if (sp_q < PTR_W'(2)) begin
          error_d    = 1'b1;
          err_code_d = 3'd2;
          state_d    = S_ERR;
        end else begin
          unique case (op_q)
            OP_ADD: begin
              stack_d[a_idx] = op_a + op_b;
              sp_d           = sp_q - PTR_W'(1);
              state_d        = S_FETCH;
            end
            OP_SUB: begin
              stack_d[a_idx] = op_a - op_b;
              sp_d           = sp_q - PTR_W'(1);
              state_d        = S_FETCH;
            end
            OP_MUL: begin
              stack_d[a_idx] = op_a * op_b;
              sp_d           = sp_q - PTR_W'(1);
              state_d        = S_FETCH;
            end
            default: begin
              if (op_b == '0) begin
                error_d    = 1'b1;
                err_code_d = 3'd4;
                state_d    = S_ERR;
              end else begin
                quo_d   = a_mag;
                dvs_d   = b_mag;
                rem_d   = '0;
                neg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_DIV;
              end
            end
          endcase
        end
      end
      S_DIV: begin
        rem_d = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d = quo_next;
        if (cnt_q == CNT_W'(1)) begin
          // Most-negative / -1 yields magnitude 2^(WIDTH-1), which wraps back to most-negative.
          stack_d[a_idx] = neg_q ? (~quo_next + WIDTH'(1)) : quo_next;
          sp_d           = sp_q - PTR_W'(1);
          state_d        = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FINAL: begin
        if (sp_q == PTR_W'(1)) begin
          result_d     = stack_q[0];
          result_stb_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          error_d    = 1'b1;
          err_code_d = 3'd5;
          state_d    = S_ERR;
        end
      end
      default: begin
        ack_d = accept;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_FETCH;
      op_q         <= OP_ADD;
      after_q      <= AFTER_FETCH;
      sp_q         <= '0;
      acc_q        <= '0;
      acc_valid_q  <= 1'b0;
      ack_q        <= 1'b0;
      result_q     <= '0;
      result_stb_q <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      neg_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      after_q      <= after_d;
      sp_q         <= sp_d;
      acc_q        <= acc_d;
      acc_valid_q  <= acc_valid_d;
      ack_q        <= ack_d;
      result_q     <= result_d;
      result_stb_q <= result_stb_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      neg_q        <= neg_d;
      stack_q      <= stack_d;
    end
  end

  assign IN_ACK     = ack_q;
  assign RESULT     = result_q;
  assign RESULT_STB = result_stb_q;
  assign ERROR      = error_q;
  assign ERR_CODE   = err_code_q;
  assign BUSY       = (state_q != S_FETCH) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule
